// File: rtl/bht_pkg.sv
// bht_pkg: shared BHT types (counter, FSM state, queued update entry), widths and the saturating-counter step
package bht_pkg;
    localparam int CNT_W = 2;
    localparam int IDX_MAX_W = 16;
    typedef logic [CNT_W-1:0] bht_cnt_t;
    typedef enum logic [1:0] {INIT, RUN, UPD_WR} bht_state_e;
    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        logic                 taken;
    } upd_entry_t;
    function automatic bht_cnt_t sat_next(input bht_cnt_t cnt, input logic taken);
        return taken ? ((&cnt) ? cnt : cnt + 1'b1) : ((|cnt) ? cnt - 1'b1 : cnt);
    endfunction
endpackage

// File: rtl/bht_upd_fifo.sv
// bht_upd_fifo: sync FIFO of upd_entry_t; clk, reset (async), clr, push/din, pop/dout (head), full, empty
module bht_upd_fifo
    import bht_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       push,
    input  upd_entry_t din,
    input  logic       pop,
    output upd_entry_t dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    upd_entry_t mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rp[AW-1:0]];
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    always_ff @(posedge clk)
        if (do_push && !clr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/bht_ctrl.sv
// bht_ctrl: single-port BHT sequencer; clk/reset/flush, busy, lookup req/pc/gnt, predict valid/taken, update valid/pc/taken/ready, mem en/we/addr/wdata/rdata
module bht_ctrl
    import bht_pkg::*;
#(
    parameter int       DEPTH      = 128,
    parameter int       UPD_DEPTH  = 4,
    parameter int       STARVE_MAX = 8,
    parameter bht_cnt_t INIT_VAL   = 2'b01,
    localparam int      IDX_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    output logic             busy,
    input  logic             lookup_req,
    input  logic [31:0]      lookup_pc,
    output logic             lookup_gnt,
    output logic             predict_valid,
    output logic             predict_taken,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [CNT_W-1:0] mem_wdata,
    input  logic [CNT_W-1:0] mem_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    bht_state_e state, state_nx;
    logic [IDX_W-1:0] sweep;
    logic [SW-1:0] starve;
    upd_entry_t rmw, head, push_ent;
    logic full, empty, pick_upd, push;
    logic unused;
    assign push_ent = '{idx: IDX_MAX_W'(upd_pc[1 +: IDX_W]), taken: upd_taken};
    assign unused = ^{lookup_pc, upd_pc, rmw.idx, head.idx};
    bht_upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .push  (push),
        .din   (push_ent),
        .pop   (pick_upd),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        busy = state == INIT;
        upd_ready = !full && !busy;
        pick_upd = state == RUN && !empty && (!lookup_req || full || starve == SW'(STARVE_MAX));
        lookup_gnt = state == RUN && lookup_req && !pick_upd;
        push = upd_valid && upd_ready && !flush;
        mem_en = state != RUN || pick_upd || lookup_gnt;
        mem_we = state != RUN;
        mem_addr = busy ? sweep : state == UPD_WR ? rmw.idx[IDX_W-1:0] : pick_upd ? head.idx[IDX_W-1:0] : lookup_pc[1 +: IDX_W];
        mem_wdata = busy ? INIT_VAL : state == UPD_WR ? sat_next(mem_rdata, rmw.taken) : '0;
        predict_taken = predict_valid && mem_rdata[1];
        state_nx = busy ? (sweep == IDX_W'(DEPTH - 1) ? RUN : INIT) : pick_upd ? UPD_WR : RUN;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= INIT;
            sweep <= '0;
            starve <= '0;
            predict_valid <= 1'b0;
            rmw <= '0;
        end else if (flush) begin
            state <= INIT;
            sweep <= '0;
            starve <= '0;
            predict_valid <= 1'b0;
        end else begin
            state <= state_nx;
            sweep <= busy ? sweep + 1'b1 : '0;
            predict_valid <= lookup_gnt;
            if (pick_upd) rmw <= head;
            if (pick_upd || empty) starve <= '0;
            else if (lookup_gnt && starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
        end
endmodule

// File: tb/tb_bht_ctrl.sv
// tb_bht_ctrl: self-checking bench for bht_ctrl with SRAM model, vector table, corner sequences and a random reference-model run
module tb_bht_ctrl;
    localparam int DEPTH = 128;
    localparam int IDX_W = 7;
    logic clk = 0, reset = 1, flush = 0;
    logic lookup_req = 0, upd_valid = 0, upd_taken = 0;
    logic [31:0] lookup_pc = 0, upd_pc = 0;
    logic busy, lookup_gnt, predict_valid, predict_taken, upd_ready, mem_en, mem_we;
    logic [IDX_W-1:0] mem_addr;
    logic [1:0] mem_wdata, mem_rdata = 0;
    logic [1:0] sram [DEPTH];
    logic b_uv = 0, b_ut = 0;
    logic [31:0] b_upc = 0;
    logic b_busy, b_gnt, b_pv, b_pt, b_rdy, b_en, b_we;
    logic [IDX_W-1:0] b_addr;
    logic [1:0] b_wd, b_rd = 0;
    logic [1:0] sram2 [DEPTH];
    always #5 clk = ~clk;
    bht_ctrl #(.DEPTH(DEPTH), .UPD_DEPTH(4), .STARVE_MAX(8), .INIT_VAL(2'b01)) dut (
        .clk(clk), .reset(reset), .flush(flush), .busy(busy),
        .lookup_req(lookup_req), .lookup_pc(lookup_pc), .lookup_gnt(lookup_gnt),
        .predict_valid(predict_valid), .predict_taken(predict_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    bht_ctrl #(.DEPTH(DEPTH), .UPD_DEPTH(4), .STARVE_MAX(8), .INIT_VAL(2'b11)) dut2 (
        .clk(clk), .reset(reset), .flush(1'b0), .busy(b_busy),
        .lookup_req(1'b0), .lookup_pc(32'h0), .lookup_gnt(b_gnt),
        .predict_valid(b_pv), .predict_taken(b_pt),
        .upd_valid(b_uv), .upd_pc(b_upc), .upd_taken(b_ut), .upd_ready(b_rdy),
        .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wd), .mem_rdata(b_rd)
    );
    always @(posedge clk) if (mem_en) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        else mem_rdata <= sram[mem_addr];
    end
    always @(posedge clk) if (b_en) begin
        if (b_we) sram2[b_addr] <= b_wd;
        else b_rd <= sram2[b_addr];
    end
    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // Reference model: table of counter values, ordered list of accepted updates,
    // and a count of consecutive lookup grants made while updates were waiting.
    typedef struct {int idx; int taken;} upd_t;
    upd_t q[$];
    int ref_tab [DEPTH];
    bit m_busy, inflight, pend;
    int sweep_exp, grants, pred_val, fcnt;
    logic exp_gnt;
    function automatic int sat(int v, int t);
        return t != 0 ? (v < 3 ? v + 1 : 3) : (v > 0 ? v - 1 : 0);
    endfunction
    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 1) % DEPTH);
    endfunction
    task automatic model_reset();
        q.delete();
        m_busy = 1; inflight = 0; pend = 0; sweep_exp = 0; grants = 0;
        foreach (ref_tab[i]) ref_tab[i] = 1;
    endtask
    always @(negedge clk) begin
        if (reset) model_reset();
        else begin
            chk("busy", busy, m_busy);
            chk("pred_valid", predict_valid, pend);
            chk("pred_taken", predict_taken, int'(pend && pred_val >= 2));
            pend = 0;
            if (m_busy) begin
                chk("init_en_we", {mem_en, mem_we}, 3);
                chk("init_addr", mem_addr, sweep_exp);
                chk("init_wdata", mem_wdata, 1);
                chk("init_gnt", lookup_gnt, 0);
                chk("init_ready", upd_ready, 0);
                sweep_exp++;
                if (sweep_exp == DEPTH) m_busy = 0;
            end else begin
                fcnt = q.size() - int'(inflight);
                chk("upd_ready", upd_ready, int'(fcnt < 4));
                if (inflight) begin
                    chk("rmw_en_we", {mem_en, mem_we}, 3);
                    chk("rmw_addr", mem_addr, q[0].idx);
                    chk("rmw_wdata", mem_wdata, sat(ref_tab[q[0].idx], q[0].taken));
                    chk("rmw_gnt", lookup_gnt, 0);
                    ref_tab[q[0].idx] = sat(ref_tab[q[0].idx], q[0].taken);
                    void'(q.pop_front());
                    inflight = 0;
                    if (fcnt == 0) grants = 0;
                end else begin
                    exp_gnt = lookup_req && (fcnt == 0 || (fcnt < 4 && grants < 8));
                    chk("gnt", lookup_gnt, exp_gnt);
                    if (exp_gnt) begin
                        chk("lk_en_we", {mem_en, mem_we}, 2);
                        chk("lk_addr", mem_addr, idx_of(lookup_pc));
                        pend = 1;
                        pred_val = ref_tab[idx_of(lookup_pc)];
                        grants = fcnt > 0 ? grants + 1 : 0;
                    end else if (fcnt > 0) begin
                        chk("upd_rd_en_we", {mem_en, mem_we}, 2);
                        chk("upd_rd_addr", mem_addr, q[0].idx);
                        inflight = 1;
                        grants = 0;
                    end else chk("idle_en", mem_en, 0);
                end
                if (upd_valid && fcnt < 4) q.push_back('{idx_of(upd_pc), int'(upd_taken)});
            end
            if (flush) model_reset();
        end
    end
    typedef struct {int lr, lpc, uv, upc, ut, gnt, en, we, addr, wd, pv, pt;} vec_t;
    vec_t vt [17];
    int n, hits;
    bit found;
    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        //        lr lpc    uv upc    ut gnt en we addr  wd pv pt
        vt[0]  = '{1, 'h24, 0, 0,    0, 1, 1, 0, 'h12, -1, 0, 0};
        vt[1]  = '{0, 0,    1, 'h24, 1, 0, 0, 0, -1,   -1, 1, 0};
        vt[2]  = '{0, 0,    1, 'h24, 1, 0, 1, 0, 'h12, -1, 0, 0};
        vt[3]  = '{0, 0,    1, 'h24, 1, 0, 1, 1, 'h12, 2,  0, 0};
        vt[4]  = '{0, 0,    0, 0,    0, 0, 1, 0, 'h12, -1, 0, 0};
        vt[5]  = '{0, 0,    0, 0,    0, 0, 1, 1, 'h12, 3,  0, 0};
        vt[6]  = '{0, 0,    0, 0,    0, 0, 1, 0, 'h12, -1, 0, 0};
        vt[7]  = '{0, 0,    0, 0,    0, 0, 1, 1, 'h12, 3,  0, 0};
        vt[8]  = '{1, 'h24, 0, 0,    0, 1, 1, 0, 'h12, -1, 0, 0};
        vt[9]  = '{0, 0,    1, 'h40, 0, 0, 0, 0, -1,   -1, 1, 1};
        vt[10] = '{0, 0,    1, 'h40, 0, 0, 1, 0, 'h20, -1, 0, 0};
        vt[11] = '{0, 0,    0, 0,    0, 0, 1, 1, 'h20, 0,  0, 0};
        vt[12] = '{0, 0,    0, 0,    0, 0, 1, 0, 'h20, -1, 0, 0};
        vt[13] = '{0, 0,    0, 0,    0, 0, 1, 1, 'h20, 0,  0, 0};
        vt[14] = '{1, 'h40, 0, 0,    0, 1, 1, 0, 'h20, -1, 0, 0};
        vt[15] = '{0, 0,    0, 0,    0, 0, 0, 0, -1,   -1, 1, 0};
        vt[16] = '{1, 'h26, 0, 0,    0, 1, 1, 0, 'h13, -1, 0, 0};
        repeat (3) step();
        chk("reset_busy", busy, 1);
        chk("reset_ready", upd_ready, 0);
        chk("reset_gnt", lookup_gnt, 0);
        chk("reset_pv", predict_valid, 0);
        reset = 0;
        n = 0;
        while (busy && n < 300) begin step(); n++; end
        chk("init_cycles", n, 128);
        chk("init_done_ready", upd_ready, 1);
        for (int i = 0; i < 17; i++) begin
            lookup_req = vt[i].lr[0]; lookup_pc = 32'(vt[i].lpc);
            upd_valid = vt[i].uv[0]; upd_pc = 32'(vt[i].upc); upd_taken = vt[i].ut[0];
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), lookup_gnt, vt[i].gnt);
            chk($sformatf("vec%0d_en", i), mem_en, vt[i].en);
            if (vt[i].en != 0) chk($sformatf("vec%0d_we", i), mem_we, vt[i].we);
            if (vt[i].addr >= 0) chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].addr);
            if (vt[i].wd >= 0) chk($sformatf("vec%0d_wdata", i), mem_wdata, vt[i].wd);
            chk($sformatf("vec%0d_pv", i), predict_valid, vt[i].pv);
            chk($sformatf("vec%0d_pt", i), predict_taken, vt[i].pt);
            step();
        end
        lookup_req = 0; upd_valid = 0;
        step();
        // full FIFO with lookups held: the fifth cycle must be a forced update
        lookup_req = 1; lookup_pc = 32'h100;
        for (int k = 0; k < 4; k++) begin
            upd_valid = 1; upd_pc = 32'h200 + 32'(8 * k); upd_taken = k[0];
            @(negedge clk);
            chk("full_push_ready", upd_ready, 1);
            step();
        end
        upd_valid = 0;
        @(negedge clk);
        chk("full_ready", upd_ready, 0);
        chk("full_forced_gnt", lookup_gnt, 0);
        chk("full_forced_rd", {mem_en, mem_we}, 2);
        lookup_req = 0;
        repeat (10) step();
        // starvation bound with a single queued update
        lookup_req = 1; upd_valid = 1; upd_pc = 32'h3a; upd_taken = 1;
        step();
        upd_valid = 0;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (!lookup_gnt) break;
            n++;
            step();
        end
        chk("starve_grants", n, 8);
        chk("starve_forced_rd", {mem_en, mem_we}, 2);
        lookup_req = 0;
        repeat (4) step();
        // flush during UPD_WR with three entries still queued
        lookup_req = 1;
        for (int k = 0; k < 4; k++) begin
            upd_valid = 1; upd_pc = 32'h500 + 32'(4 * k); upd_taken = 1;
            step();
        end
        upd_valid = 0;
        step();
        flush = 1; upd_valid = 1; upd_pc = 32'h600;
        @(negedge clk);
        chk("flush_in_updwr", mem_we, 1);
        step();
        flush = 0; upd_valid = 0; lookup_req = 0;
        chk("flush_busy", busy, 1);
        chk("flush_ready", upd_ready, 0);
        n = 0;
        while (busy && n < 300) begin step(); n++; end
        chk("flush_sweep_cycles", n, 128);
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_en) hits++;
            step();
        end
        chk("flush_no_stale_upd", hits, 0);
        // random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            lookup_req = $urandom_range(0, 3) != 0;
            lookup_pc = $urandom;
            lookup_pc[7:1] = 7'($urandom_range(0, 15));
            upd_valid = $urandom_range(0, 2) != 0;
            upd_pc = $urandom;
            upd_pc[7:1] = 7'($urandom_range(0, 15));
            upd_taken = $urandom_range(0, 1) != 0;
            flush = $urandom_range(0, 599) == 0;
            step();
        end
        flush = 0; upd_valid = 0; lookup_req = 0;
        // asynchronous reset between edges
        n = 0;
        while (busy && n < 300) begin step(); n++; end
        chk("pre_reset_idle", busy, 0);
        lookup_req = 1; lookup_pc = 32'h10;
        step();
        lookup_req = 0;
        #2 reset = 1;
        #1;
        chk("async_busy", busy, 1);
        chk("async_pv", predict_valid, 0);
        chk("async_ready", upd_ready, 0);
        chk("async_addr", mem_addr, 0);
        step();
        reset = 0;
        n = 0;
        while (busy && n < 300) begin step(); n++; end
        chk("reinit_cycles", n, 128);
        // INIT_VAL=11 instance: sweep writes 11, taken update saturates at 11
        n = 0;
        while (b_busy && n < 300) begin step(); n++; end
        chk("iv11_ready", b_rdy, 1);
        chk("iv11_sweep_val", sram2[5], 3);
        b_uv = 1; b_upc = 32'h8; b_ut = 1;
        step();
        b_uv = 0;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (b_en && b_we) begin
                found = 1;
                chk("iv11_addr", b_addr, 4);
                chk("iv11_wdata", b_wd, 3);
            end
            step();
        end
        chk("iv11_write_seen", found, 1);
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
